ula_operand_sequencer: RTL
==========================

ULA_OPERAND_SEQUENCER -- requirements
Module: ula_operand_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, cycles a raw key level must hold before it is accepted.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000, cycles allowed in WAIT for a result.
REQ-003 CLOCK_50  in  1  single clock; every flop is clocked on its rising edge.
REQ-004 reset_n  in  1  reset; synchronous and active-low.
REQ-005 SW  in  10  board switches; SW[3:0] is the operand/opcode value, SW[8] is carry-in.
REQ-006 KEY  in  2  raw active-low buttons; KEY[0] is ENTER, KEY[1] is CANCEL.
REQ-007 op_a, op_b  out  4 each  latched operands.
REQ-008 cin  out  1  latched carry-in.
REQ-009 opcode  out  3  latched selector, using the ULA encoding 000 soma … 110 divisao.
REQ-010 req_valid  out  1  operation request to the ULA wrapper.
REQ-011 req_ready  in  1  wrapper accepts the request.
REQ-012 res_valid  in  1  single-cycle result strobe.
REQ-013 res_data  in  8  result value.
REQ-014 result  out  8  held result for BCD/7-seg display.
REQ-015 state_led  out  3  one-hot LOAD_A/LOAD_B/LOAD_OP indicator; all zero in ISSUE/WAIT/SHOW.
REQ-016 err  out  1  sticky error flag.

Function
REQ-017 Each KEY SHALL be debounced independently: the accepted level updates only after the raw level differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-018 A press SHALL be a one-cycle pulse on the accepted level's 1->0 transition; a held key produces exactly one pulse.
REQ-019 FSM states SHALL be LOAD_A, LOAD_B, LOAD_OP, ISSUE, WAIT, SHOW; the transition SHALL occur on the clock edge after the press pulse.
REQ-020 LOAD_A + ENTER: op_a<=SW[3:0], cin<=SW[8], err<=0, go to LOAD_B.
REQ-021 LOAD_B + ENTER: op_b<=SW[3:0], go to LOAD_OP.
REQ-022 LOAD_OP + ENTER with SW[2:0]!=111: opcode<=SW[2:0], go to ISSUE; with SW[2:0]=111: err<=1, stay in LOAD_OP, opcode unchanged.
REQ-023 ISSUE: req_valid=1, and op_a/op_b/cin/opcode SHALL stay stable while req_valid=1; on req_valid&req_ready go to WAIT with req_valid=0 on the next cycle.
REQ-024 WAIT: on res_valid, result<=res_data, go to SHOW; a res_valid in any other state SHALL be ignored.
REQ-025 WAIT timeout: after TIMEOUT_CYCLES cycles without res_valid, result<=0, err<=1, go to SHOW; res_valid in the final counted cycle wins over the timeout.
REQ-026 SHOW + ENTER: go to LOAD_A; result is held until the next capture.
REQ-027 CANCEL in LOAD_B, LOAD_OP or SHOW: go to LOAD_A with latched values retained; CANCEL in LOAD_A, ISSUE or WAIT SHALL be ignored.
REQ-028 ENTER and CANCEL pulsing in the same cycle: CANCEL wins where valid; otherwise ENTER applies.
REQ-029 Presses in ISSUE and WAIT SHALL be discarded, not queued.

Reset
REQ-030 When reset_n=0 at a clock edge: state=LOAD_A; op_a, op_b, cin, opcode, result = 0; req_valid = 0; err = 0; state_led = 001; debounce counters = 0; accepted key levels = 1 (released).
REQ-031 Reset in ISSUE or WAIT SHALL drop req_valid in the same cycle and discard any pending result.

Structure
REQ-032 Package ula_seq_pkg SHALL hold the state encoding and opcode constants (OP_SOMA=000 … OP_DIV=110, OP_NONE=111).
REQ-033 One sub-module, key_debounce (debounce plus press pulse), SHALL be instantiated once per KEY.

Verification (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=8)
REQ-034 Full sequence: A=5, cin=1, B=3, op=000, ready asserted 2 cycles after valid, res_data=9 after 3 cycles -> op_a=5, cin=1, op_b=3, opcode=000, req_valid high for exactly 3 cycles, result=9, state SHOW, err=0.
REQ-035 KEY[0] bounces 0/1 every 2 cycles for 10 cycles, then holds 0 for 20 cycles -> exactly one press pulse and one state advance.
REQ-036 LOAD_OP with SW[2:0]=111 + ENTER -> err=1, state stays LOAD_OP; SW=100 + ENTER -> ISSUE, opcode=100.
REQ-037 No res_valid in WAIT -> after 8 cycles result=0, err=1, state SHOW.
REQ-038 Simultaneous ENTER/CANCEL in LOAD_B -> LOAD_A with op_a kept; CANCEL in WAIT -> ignored.
REQ-039 reset_n low for 1 cycle during ISSUE -> next cycle req_valid=0, state LOAD_A, all outputs 0.

Source files
------------

// File: rtl/ula_seq_pkg.sv
// Shared state encoding, ULA opcode constants and small decode helpers for the operand sequencer.
// Pure definitions: no latency, no flow control.
package ula_seq_pkg;

   typedef enum logic [2:0] {
      ST_LOAD_A  = 3'd0,
      ST_LOAD_B  = 3'd1,
      ST_LOAD_OP = 3'd2,
      ST_ISSUE   = 3'd3,
      ST_WAIT    = 3'd4,
      ST_SHOW    = 3'd5
   } state_t;

   localparam logic [2:0] OP_SOMA = 3'b000;
   localparam logic [2:0] OP_DIV  = 3'b110;
   localparam logic [2:0] OP_NONE = 3'b111;

   // The ULA decodes OP_SOMA..OP_DIV; OP_NONE is the only unused code.
   function automatic logic op_legal(input logic [2:0] op);
      return (op != OP_NONE) && (op <= OP_DIV);
   endfunction

   function automatic logic [2:0] led_of(input state_t s);
      case (s)
         ST_LOAD_A:  return 3'b001;
         ST_LOAD_B:  return 3'b010;
         ST_LOAD_OP: return 3'b100;
         default:    return 3'b000;
      endcase
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Debounces one raw active-low key; emits a one-cycle press on the accepted 1->0 edge.
// Press lags a clean raw edge by DEBOUNCE_CYCLES cycles; no backpressure, a held key pulses once.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic key_raw,
   output logic press
);

   localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [CW-1:0] cnt;
   logic          level;

   // Any cycle where raw agrees with the accepted level restarts the count.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt   <= '0;
         level <= 1'b1;
         press <= 1'b0;
      end else begin
         press <= 1'b0;
         if (key_raw == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            level <= key_raw;
            press <= level;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ula_operand_sequencer.sv
// Collects A, B, carry-in and opcode from switches, issues one ULA request and holds the result.
// Request waits on req_ready with operands frozen; result wait is bounded by TIMEOUT_CYCLES.
module ula_operand_sequencer
   import ula_seq_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int TIMEOUT_CYCLES  = 1000
) (
   input  logic       CLOCK_50,
   input  logic       reset_n,
   input  logic [9:0] SW,
   input  logic [1:0] KEY,
   output logic [3:0] op_a,
   output logic [3:0] op_b,
   output logic       cin,
   output logic [2:0] opcode,
   output logic       req_valid,
   input  logic       req_ready,
   input  logic       res_valid,
   input  logic [7:0] res_data,
   output logic [7:0] result,
   output logic [2:0] state_led,
   output logic       err
);

   localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   state_t        state, state_nxt;
   logic [TW-1:0] tcnt, tcnt_nxt;
   logic [3:0]    op_a_nxt, op_b_nxt;
   logic          cin_nxt, err_nxt;
   logic [2:0]    opcode_nxt;
   logic [7:0]    result_nxt;
   logic          enter_press, cancel_press, cancel_ok;
   logic          unused_sw;

   assign unused_sw = ^{SW[9], SW[7:4]};

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
      .clk     (CLOCK_50),
      .reset_n (reset_n),
      .key_raw (KEY[0]),
      .press   (enter_press)
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cancel_db (
      .clk     (CLOCK_50),
      .reset_n (reset_n),
      .key_raw (KEY[1]),
      .press   (cancel_press)
   );

   always_comb begin
      state_nxt  = state;
      tcnt_nxt   = '0;
      op_a_nxt   = op_a;
      op_b_nxt   = op_b;
      cin_nxt    = cin;
      opcode_nxt = opcode;
      result_nxt = result;
      err_nxt    = err;
      cancel_ok  = cancel_press && (state inside {ST_LOAD_B, ST_LOAD_OP, ST_SHOW});
      // Gated by reset so a request is withdrawn in the very cycle reset is applied.
      req_valid  = reset_n && (state == ST_ISSUE);
      state_led  = led_of(state);

      case (state)
         ST_LOAD_A: begin
            if (enter_press) begin
               op_a_nxt  = SW[3:0];
               cin_nxt   = SW[8];
               err_nxt   = 1'b0;
               state_nxt = ST_LOAD_B;
            end
         end
         ST_LOAD_B: begin
            if (cancel_ok) begin
               state_nxt = ST_LOAD_A;
            end else if (enter_press) begin
               op_b_nxt  = SW[3:0];
               state_nxt = ST_LOAD_OP;
            end
         end
         ST_LOAD_OP: begin
            if (cancel_ok) begin
               state_nxt = ST_LOAD_A;
            end else if (enter_press) begin
               if (op_legal(SW[2:0])) begin
                  opcode_nxt = SW[2:0];
                  state_nxt  = ST_ISSUE;
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end
         ST_ISSUE: begin
            if (req_ready) state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            // A result in the last counted cycle takes priority over the timeout.
            if (res_valid) begin
               result_nxt = res_data;
               state_nxt  = ST_SHOW;
            end else if (tcnt == TO_LAST) begin
               result_nxt = '0;
               err_nxt    = 1'b1;
               state_nxt  = ST_SHOW;
            end else begin
               tcnt_nxt = tcnt + 1'b1;
            end
         end
         ST_SHOW: begin
            if (cancel_ok || enter_press) state_nxt = ST_LOAD_A;
         end
         default: state_nxt = ST_LOAD_A;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) begin
         state  <= ST_LOAD_A;
         tcnt   <= '0;
         op_a   <= '0;
         op_b   <= '0;
         cin    <= 1'b0;
         opcode <= OP_SOMA;
         result <= '0;
         err    <= 1'b0;
      end else begin
         state  <= state_nxt;
         tcnt   <= tcnt_nxt;
         op_a   <= op_a_nxt;
         op_b   <= op_b_nxt;
         cin    <= cin_nxt;
         opcode <= opcode_nxt;
         result <= result_nxt;
         err    <= err_nxt;
      end
   end

endmodule
